// File: rtl/apb_completer_regbank.sv
// apb_completer_regbank: APB completer with a 16-bit register bank, fixed wait states and a read-only ID slot (optional APB_PROTOCOL_CHECK_EN)
module apb_completer_regbank #(
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_STATES = 1,
   parameter logic [15:0] ID_VALUE    = 16'hA5B0
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic [7:0]              PADDR,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [15:0]             PWDATA,
   output logic [15:0]             PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR,
   output logic [16*NUM_REGS-1:0]  cfg_regs_o,
   output logic                    proto_err_o
);
   typedef enum logic [1:0] {IDLE_ST, WAIT_ST, RESP_ST} state_t;
   state_t state, state_n;
   logic [7:0] addr_q, addr_n;
   logic wr_q, wr_n;
   logic [15:0] wdata_q, wdata_n;
   logic [3:0] cnt_q, cnt_n;
   logic [15:0] regs [NUM_REGS-1];
   logic [15:0] rd_val, prdata_n;
   logic setup, err_n, err_q, pready_n, pslverr_n, commit;
   function automatic logic err_of(input logic [7:0] a, input logic w);
      return a[0] | ({25'd0, a[7:1]} >= 32'(NUM_REGS)) | (w & (a[7:1] == 7'(NUM_REGS-1)));
   endfunction
   assign setup = (state == IDLE_ST) & PSEL & ~PENABLE;
   assign err_n = err_of(addr_n, wr_n);
   assign err_q = err_of(addr_q, wr_q);
   assign commit = (state == RESP_ST) & PSEL & PENABLE & wr_q & ~err_q;
   // next state, transfer capture and wait counter
   always_comb begin
      state_n = state;
      addr_n = addr_q;
      wr_n = wr_q;
      wdata_n = wdata_q;
      cnt_n = cnt_q;
      case (state)
         IDLE_ST: if (setup) begin
            addr_n = PADDR;
            wr_n = PWRITE;
            wdata_n = PWDATA;
            cnt_n = 4'(WAIT_STATES);
            state_n = (WAIT_STATES == 0) ? RESP_ST : WAIT_ST;
         end
         WAIT_ST: begin
            cnt_n = cnt_q - 4'd1;
            state_n = !PSEL ? IDLE_ST : (cnt_q <= 4'd1) ? RESP_ST : WAIT_ST;
         end
         default: state_n = IDLE_ST;
      endcase
   end
   // read mux on the address being latched so the response is ready on entry to RESP_ST
   always_comb begin
      rd_val = (addr_n[7:1] == 7'(NUM_REGS-1)) ? ID_VALUE : 16'h0000;
      for (int i = 0; i < NUM_REGS-1; i++)
         if (addr_n[7:1] == 7'(i)) rd_val = regs[i];
   end
   assign pready_n = (state_n == RESP_ST);
   assign pslverr_n = pready_n & err_n;
   assign prdata_n = (pready_n & ~wr_n & ~err_n) ? rd_val : 16'h0000;
   // state, latched transfer and registered response outputs
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state <= IDLE_ST;
         addr_q <= '0;
         wr_q <= 1'b0;
         wdata_q <= '0;
         cnt_q <= '0;
         PRDATA <= '0;
         PREADY <= 1'b0;
         PSLVERR <= 1'b0;
      end else begin
         state <= state_n;
         addr_q <= addr_n;
         wr_q <= wr_n;
         wdata_q <= wdata_n;
         cnt_q <= cnt_n;
         PRDATA <= prdata_n;
         PREADY <= pready_n;
         PSLVERR <= pslverr_n;
      end
   end
   // writable registers; commit only on the response edge of a legal write
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         for (int i = 0; i < NUM_REGS-1; i++) regs[i] <= '0;
      end else if (commit) begin
         for (int i = 0; i < NUM_REGS-1; i++)
            if (addr_q[7:1] == 7'(i)) regs[i] <= wdata_q;
      end
   end
   for (genvar g = 0; g < NUM_REGS-1; g++) begin : g_cfg
      assign cfg_regs_o[16*g +: 16] = regs[g];
   end
   assign cfg_regs_o[16*(NUM_REGS-1) +: 16] = ID_VALUE;
`ifdef APB_PROTOCOL_CHECK_EN
   logic viol;
   assign viol = ((state == IDLE_ST) & PENABLE) |
                 ((state != IDLE_ST) & (~PSEL | (PADDR != addr_q) | (PWRITE != wr_q) | (PWDATA != wdata_q)));
   // sticky protocol violation flag
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) proto_err_o <= 1'b0;
      else proto_err_o <= proto_err_o | viol;
   end
`else
   assign proto_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_apb_completer_regbank.sv
// tb_apb_completer_regbank: table-driven and randomized checks of apb_completer_regbank against a register-array model
module tb_apb_completer_regbank;
   localparam int N = 16;
   localparam int WS = 1;
   localparam logic [15:0] ID = 16'hA5B0;
`ifdef APB_PROTOCOL_CHECK_EN
   localparam logic PROTO = 1'b1;
`else
   localparam logic PROTO = 1'b0;
`endif
   logic PCLK = 1'b0, PRESET = 1'b1;
   logic [7:0] PADDR = '0;
   logic PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [15:0] PWDATA = '0;
   logic [15:0] PRDATA;
   logic PREADY, PSLVERR, proto_err_o;
   logic [16*N-1:0] cfg_regs_o;
   int checks = 0, errors = 0;
   logic [15:0] model [N];
   apb_completer_regbank dut (
      .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR), .cfg_regs_o(cfg_regs_o), .proto_err_o(proto_err_o)
   );
   always #5 PCLK = ~PCLK;
   typedef struct {
      logic [7:0]  a;
      logic        w;
      logic [15:0] d;
      logic [15:0] erd;
      logic        eerr;
   } vec_t;
   vec_t tbl [12];
   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic logic [255:0] cfg_exp();
      logic [255:0] v;
      for (int i = 0; i < N-1; i++) v[16*i +: 16] = model[i];
      v[16*(N-1) +: 16] = ID;
      return v;
   endfunction
   function automatic logic mdl_err(input logic [7:0] a, input logic w);
      int idx = int'(a) / 2;
      return (a % 2 == 1) || idx >= N || (w && idx == N-1);
   endfunction
   task automatic clear_model();
      for (int i = 0; i < N; i++) model[i] = 16'h0000;
   endtask
   task automatic xfer(input logic [7:0] a, input logic w, input logic [15:0] d,
                       input logic [7:0] a2, input logic [15:0] d2,
                       output logic [15:0] rd, output logic er, output int cyc);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1; PADDR = a2; PWDATA = d2;
      cyc = -1; rd = '0; er = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge PCLK);
         if (PREADY) begin
            cyc = n; rd = PRDATA; er = PSLVERR;
            break;
         end
      end
      if (cyc < 0) chk("pready_timeout", 0, 1);
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
      @(negedge PCLK);
      chk("pready_one_cycle", PREADY, 1'b0);
   endtask
   task automatic run(input string nm, input logic [7:0] a, input logic w, input logic [15:0] d,
                      input logic [15:0] erd, input logic eerr);
      logic [15:0] rd;
      logic er;
      int cyc;
      xfer(a, w, d, a, d, rd, er, cyc);
      if (w && !eerr) model[int'(a) / 2] = d;
      chk({nm, "_prdata"}, rd, erd);
      chk({nm, "_pslverr"}, er, eerr);
      chk({nm, "_latency"}, cyc, WS);
      chk({nm, "_cfg"}, cfg_regs_o, cfg_exp());
   endtask
   initial begin
      logic [15:0] rd, erd;
      logic er, w;
      logic [7:0] a;
      logic [15:0] d;
      int cyc;
      tbl[0]  = '{8'h04, 1'b1, 16'hBEEF, 16'h0000, 1'b0};
      tbl[1]  = '{8'h04, 1'b0, 16'h0000, 16'hBEEF, 1'b0};
      tbl[2]  = '{8'h05, 1'b1, 16'h1111, 16'h0000, 1'b1};
      tbl[3]  = '{8'h40, 1'b1, 16'h2222, 16'h0000, 1'b1};
      tbl[4]  = '{8'h1E, 1'b1, 16'h3333, 16'h0000, 1'b1};
      tbl[5]  = '{8'h1E, 1'b0, 16'h0000, 16'hA5B0, 1'b0};
      tbl[6]  = '{8'h05, 1'b0, 16'h0000, 16'h0000, 1'b1};
      tbl[7]  = '{8'hFF, 1'b0, 16'h0000, 16'h0000, 1'b1};
      tbl[8]  = '{8'h08, 1'b1, 16'h1357, 16'h0000, 1'b0};
      tbl[9]  = '{8'h08, 1'b0, 16'h0000, 16'h1357, 1'b0};
      tbl[10] = '{8'h1C, 1'b1, 16'hFFFF, 16'h0000, 1'b0};
      tbl[11] = '{8'h1C, 1'b0, 16'h0000, 16'hFFFF, 1'b0};
      clear_model();
      repeat (3) @(posedge PCLK);
      #1;
      chk("rst_pready", PREADY, 1'b0);
      chk("rst_prdata", PRDATA, 16'h0000);
      chk("rst_pslverr", PSLVERR, 1'b0);
      chk("rst_proto", proto_err_o, 1'b0);
      chk("rst_cfg", cfg_regs_o, cfg_exp());
      PRESET = 1'b0;
      // reset while a write to idx 3 sits in its wait state
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 8'h06; PWRITE = 1'b1; PWDATA = 16'h1234;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #1 PRESET = 1'b1;
      #1;
      chk("midrst_pready", PREADY, 1'b0);
      repeat (2) @(posedge PCLK);
      #1 PSEL = 1'b0; PENABLE = 1'b0; PRESET = 1'b0;
      repeat (2) @(negedge PCLK);
      chk("midrst_reg3", cfg_regs_o[63:48], 16'h0000);
      chk("midrst_pready_after", PREADY, 1'b0);
      for (int i = 0; i < N-1; i++) run("rd_reset", 8'(2*i), 1'b0, 16'h0000, 16'h0000, 1'b0);
      run("rd_id", 8'h1E, 1'b0, 16'h0000, ID, 1'b0);
      for (int i = 0; i < 12; i++)
         run($sformatf("tbl%0d", i), tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].erd, tbl[i].eerr);
      for (int i = 0; i < 150; i++) begin
         a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'(2 * $urandom_range(0, N-1));
         w = 1'($urandom_range(0, 1));
         d = 16'($urandom);
         er = mdl_err(a, w);
         erd = (w || er) ? 16'h0000 : (int'(a) / 2 == N-1) ? ID : model[int'(a) / 2];
         run("rand", a, w, d, erd, er);
      end
      chk("proto_clean", proto_err_o, 1'b0);
      // manager abort in the wait state: no write, no response
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PADDR = 8'h0A; PWRITE = 1'b1; PWDATA = 16'h7777 ^ model[5];
      @(posedge PCLK); #1;
      PSEL = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge PCLK);
         chk("abort_pready", PREADY, 1'b0);
      end
      chk("abort_cfg", cfg_regs_o, cfg_exp());
      // address/data changed in the access phase: latched values win
      @(posedge PCLK); #1 PRESET = 1'b1;
      #1 PRESET = 1'b0;
      clear_model();
      @(negedge PCLK);
      chk("proto_rst", proto_err_o, 1'b0);
      xfer(8'h02, 1'b1, 16'hAAAA, 8'h06, 16'h5555, rd, er, cyc);
      model[1] = 16'hAAAA;
      chk("latch_pslverr", er, 1'b0);
      chk("latch_latency", cyc, WS);
      chk("latch_cfg", cfg_regs_o, cfg_exp());
      chk("proto_set", proto_err_o, PROTO);
      repeat (4) @(negedge PCLK);
      chk("proto_sticky", proto_err_o, PROTO);
      @(posedge PCLK); #1 PRESET = 1'b1;
      #1;
      chk("proto_cleared", proto_err_o, 1'b0);
      #1 PRESET = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
